// File: rtl/load_store_unit.sv
// Load/store unit: takes one request from execute, decodes size/alignment, runs a
// single memory handshake with an ack timeout, and returns extended load data.
module load_store_unit #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic [1:0]  err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_REQ  = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;

  localparam logic [6:0]  OP_LOAD  = 7'b0000011;
  localparam logic [6:0]  OP_STORE = 7'b0100011;
  localparam logic [15:0] TMO_LAST = 16'(ACK_TIMEOUT - 1);

  logic [1:0]  r_state;
  logic [15:0] r_cnt;
  logic [2:0]  r_funct3;
  logic [1:0]  r_lane;

  logic        w_is_load, w_is_store, w_legal, w_misal;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ldata;

  // Request decode, evaluated on the start cycle only
  always_comb begin
    w_is_load  = (opcode == OP_LOAD);
    w_is_store = (opcode == OP_STORE);
    w_legal    = (w_is_load  && (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) ||
                 (w_is_store && (funct3 inside {3'b000, 3'b001, 3'b010}));
    w_misal    = ((funct3[1:0] == 2'b01) && addr[0]) ||
                 ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    w_be       = 4'b1111;
    w_wdata    = wdata;
    if (w_is_store) begin
      case (funct3[1:0])
        2'b00: begin
          w_be    = 4'b0001 << addr[1:0];
          w_wdata = {4{wdata[7:0]}};
        end
        2'b01: begin
          w_be    = 4'b0011 << {addr[1], 1'b0};
          w_wdata = {2{wdata[15:0]}};
        end
        default: ;
      endcase
    end
  end

  // Lane select and extension of the returned word
  always_comb begin
    w_byte = mem_rdata[8*r_lane +: 8];
    w_half = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_funct3)
      3'b000:  w_ldata = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_ldata = {24'b0, w_byte};
      3'b001:  w_ldata = {{16{w_half[15]}}, w_half};
      3'b101:  w_ldata = {16'b0, w_half};
      default: w_ldata = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_funct3  <= '0;
      r_lane    <= '0;
      rdata     <= '0;
      err       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (!w_legal || w_misal) begin
              r_state <= S_DONE;
              err     <= !w_legal ? 2'd2 : 2'd1;
            end else begin
              r_state   <= S_REQ;
              r_cnt     <= '0;
              r_funct3  <= funct3;
              r_lane    <= addr[1:0];
              err       <= 2'd0;
              mem_req   <= 1'b1;
              mem_we    <= w_is_store;
              mem_addr  <= {addr[31:2], 2'b00};
              mem_be    <= w_be;
              mem_wdata <= w_wdata;
            end
          end
        end
        S_REQ: begin
          // ack takes priority over a timeout landing on the same cycle
          if (mem_ack) begin
            r_state <= S_DONE;
            mem_req <= 1'b0;
            err     <= 2'd0;
            if (!mem_we) rdata <= w_ldata;
          end else if (r_cnt == TMO_LAST) begin
            r_state <= S_DONE;
            mem_req <= 1'b0;
            err     <= 2'd3;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE);

endmodule
